alu_wb_stage: RTL
=================

Name: alu_wb_stage

Overview:
- Execute/writeback register stage directly downstream of the ALU.
- Captures the ALU result, carry, overflow, non-zero and multi-cycle outputs, and registers the regfile write.
- Maintains the architectural flag register (C, V, Z, S) and resolves the DJNZ loop condition.
- Holds off the pipeline for multi-cycle ALU operations (32x32 MUL) via a stall handshake.

Parameters:
- MCP_CYCLES, 2: extra cycles held when alu_mcp=1; legal range 1..7.
- RF_ADDR_W, 4: register-file address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- valid_in  in  1  ALU outputs and sideband are a valid instruction this cycle
- opcode  in  6  opcode of the instruction in the ALU
- rdest  in  RF_ADDR_W  destination register
- alu_dout  in  32  ALU result
- alu_cout  in  1  ALU carry out
- alu_vout  in  1  ALU overflow out
- alu_qnz  in  1  ALU DJNZ non-zero result
- alu_mcp  in  1  ALU multi-cycle-path request
- flush  in  1  kill in-flight and incoming instruction
- stall_out  out  1  upstream must hold ALU operands and opcode
- rf_we  out  1  registered regfile write enable
- rf_waddr  out  RF_ADDR_W  registered write address
- rf_wdata  out  32  registered write data
- flags  out  4  {C,V,Z,S} architectural flags
- djnz_taken  out  1  one-cycle pulse: DJNZ result non-zero, branch taken

Behaviour:
- Reset values (synchronous rst=1): rf_we=0, rf_waddr=0, rf_wdata=0, flags=0, djnz_taken=0, stall_out=0, state=IDLE, counter=0. rst overrides every other input, including mid-MCP.
- FSM states: IDLE, MCP_WAIT.
- IDLE, valid_in=1, alu_mcp=0, flush=0: commit on the next edge. Latency is 1 cycle from ALU output to rf_we/flags.
- IDLE, valid_in=1, alu_mcp=1, flush=0:
  - stall_out asserts combinationally in the same cycle.
  - Go to MCP_WAIT and load counter=MCP_CYCLES-1. Nothing is committed.
- MCP_WAIT: stall_out=1. Counter decrements each cycle. Upstream holds its inputs stable; alu_mcp is ignored while in this state.
  - When counter=0, stall_out=0 in that cycle.
  - The current alu_* values commit at that cycle's edge. The FSM returns to IDLE.
  - Total occupancy is MCP_CYCLES+1 cycles (3 at default).
- flush=1 in any state:
  - No commit at the next edge, and the FSM goes to IDLE.
  - stall_out=0 in the flush cycle.
  - Flush wins over a simultaneous valid_in or MCP completion.
- rf_we, djnz_taken: single-cycle pulses. They deassert on the edge after each commit unless a new commit occurs.
- Commit rules, by opcode:
  - Writes rf (rf_we=1, rf_waddr=rdest, rf_wdata=alu_dout): MOV, LMOV, LMOVT, AND, OR, XOR, ADD, SUB, MUL, DJNZ, BSET, BCLR, ASL, ASR, LSR, ROL, ROR.
  - No write: CMP, BTST.
  - Z = (alu_dout==0); S = alu_dout[31].
  - Flag updates:
    - ADD, SUB, CMP, MUL: C, V, Z, S.
    - AND, OR, XOR, ASL, ASR, LSR, ROL, ROR: C, Z, S; V holds.
    - BTST: Z only.
    - MOV, LMOV, LMOVT, BSET, BCLR, DJNZ: no flag change.
  - DJNZ: djnz_taken=alu_qnz.
  - Unknown opcode: no write, no flag change.
- rf_wdata holds its last value when rf_we=0.
- stall_out never asserts in IDLE without valid_in&alu_mcp&!flush.

Decomposition:
- Opcode `defines stay in cpu_2432.vh. Add there: flag bit positions (FLAG_C=3, FLAG_V=2, FLAG_Z=1, FLAG_S=0) and the state encodings.
- One sub-module, alu_flag_update: combinational opcode -> {write_en, flag update mask} decode. It is instantiated once; the FSM and registers stay in alu_wb_stage.

Test Plan:
- ADD, alu_dout=0x0000_0000, cout=1, vout=0, rdest=3 -> next cycle rf_we=1, waddr=3, wdata=0; flags={1,0,1,0}.
- CMP, alu_dout=0x8000_0001, cout=0, vout=1 -> rf_we=0; flags={0,1,0,1}.
- MUL with alu_mcp=1, MCP_CYCLES=2, dout=0x1234_5678 -> stall_out high for exactly 2 cycles, then rf_we pulses one edge later with wdata=0x1234_5678. Total occupancy is 3 cycles.
- DJNZ, alu_qnz=1, then DJNZ with alu_qnz=0 -> djnz_taken pulses 1 then 0; flags unchanged; both write rf.
- MUL mcp in progress, flush asserted in its 2nd cycle -> no rf_we, flags unchanged, stall_out=0 that cycle, FSM back to IDLE. Same sequence with rst instead of flush -> all outputs return to reset values.
- Back-to-back: XOR (flags C=0, Z=0 from dout=0x5) immediately followed by BTST with dout=0 -> Z goes 0 then 1; C stays 0; V unchanged.

Source files
------------

// File: rtl/alu_wb_stage_pkg.sv
// Shared opcode encodings, flag bit positions, FSM states and flag masks
// for the ALU writeback stage.
package alu_wb_stage_pkg;

    localparam logic [5:0] OP_MOV   = 6'h01;
    localparam logic [5:0] OP_LMOV  = 6'h02;
    localparam logic [5:0] OP_LMOVT = 6'h03;
    localparam logic [5:0] OP_AND   = 6'h04;
    localparam logic [5:0] OP_OR    = 6'h05;
    localparam logic [5:0] OP_XOR   = 6'h06;
    localparam logic [5:0] OP_ADD   = 6'h07;
    localparam logic [5:0] OP_SUB   = 6'h08;
    localparam logic [5:0] OP_CMP   = 6'h09;
    localparam logic [5:0] OP_MUL   = 6'h0A;
    localparam logic [5:0] OP_DJNZ  = 6'h0B;
    localparam logic [5:0] OP_BSET  = 6'h0C;
    localparam logic [5:0] OP_BCLR  = 6'h0D;
    localparam logic [5:0] OP_BTST  = 6'h0E;
    localparam logic [5:0] OP_ASL   = 6'h0F;
    localparam logic [5:0] OP_ASR   = 6'h10;
    localparam logic [5:0] OP_LSR   = 6'h11;
    localparam logic [5:0] OP_ROL   = 6'h12;
    localparam logic [5:0] OP_ROR   = 6'h13;

    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_S = 0;

    localparam logic [3:0] MASK_CVZS = 4'b1111;
    localparam logic [3:0] MASK_CZS  = 4'b1011;
    localparam logic [3:0] MASK_Z    = 4'b0010;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    typedef enum logic {
        StIdle    = 1'b0,
        StMcpWait = 1'b1
    } wb_state_e;

endpackage

// File: rtl/alu_wb_stage_flag_update.sv
// Combinational opcode decode: regfile write enable, flag update mask and
// DJNZ identification.
module alu_flag_update
    import alu_wb_stage_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       write_en,
    output logic [3:0] flag_mask,
    output logic       is_djnz
);

    always_comb begin
        write_en  = 1'b0;
        flag_mask = MASK_NONE;
        is_djnz   = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL: begin
                write_en  = 1'b1;
                flag_mask = MASK_CVZS;
            end
            OP_CMP: flag_mask = MASK_CVZS;
            OP_AND, OP_OR, OP_XOR, OP_ASL, OP_ASR, OP_LSR, OP_ROL, OP_ROR: begin
                write_en  = 1'b1;
                flag_mask = MASK_CZS;
            end
            OP_BTST: flag_mask = MASK_Z;
            OP_MOV, OP_LMOV, OP_LMOVT, OP_BSET, OP_BCLR: write_en = 1'b1;
            OP_DJNZ: begin
                write_en = 1'b1;
                is_djnz  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute/writeback register stage: registers the regfile write, maintains
// the {C,V,Z,S} flags and stalls upstream for multi-cycle ALU operations.
module alu_wb_stage
    import alu_wb_stage_pkg::*;
#(
    parameter int unsigned MCP_CYCLES = 2,
    parameter int unsigned RF_ADDR_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [5:0]           opcode,
    input  logic [RF_ADDR_W-1:0] rdest,
    input  logic [31:0]          alu_dout,
    input  logic                 alu_cout,
    input  logic                 alu_vout,
    input  logic                 alu_qnz,
    input  logic                 alu_mcp,
    input  logic                 flush,
    output logic                 stall_out,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic [3:0]           flags,
    output logic                 djnz_taken
);

    localparam logic [2:0] CntLoad = 3'(MCP_CYCLES - 1);

    wb_state_e            state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 commit;
    logic                 write_en;
    logic [3:0]           flag_mask;
    logic                 is_djnz;
    logic [3:0]           flag_new;
    logic [3:0]           flags_d;
    logic                 rf_we_q;
    logic [RF_ADDR_W-1:0] rf_waddr_q;
    logic [31:0]          rf_wdata_q;
    logic [3:0]           flags_q;
    logic                 djnz_q;

    alu_flag_update u_flag_update (
        .opcode    (opcode),
        .write_en  (write_en),
        .flag_mask (flag_mask),
        .is_djnz   (is_djnz)
    );

    always_comb begin
        flag_new         = '0;
        flag_new[FLAG_C] = alu_cout;
        flag_new[FLAG_V] = alu_vout;
        flag_new[FLAG_Z] = (alu_dout == 32'd0);
        flag_new[FLAG_S] = alu_dout[31];
        flags_d          = (flags_q & ~flag_mask) | (flag_new & flag_mask);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        stall_out = 1'b0;
        if (rst || flush) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (valid_in && alu_mcp) begin
                        stall_out = 1'b1;
                        state_d   = StMcpWait;
                        cnt_d     = CntLoad;
                    end else if (valid_in) begin
                        commit = 1'b1;
                    end
                end
                StMcpWait: begin
                    // Upstream holds operands, so the last wait cycle commits what it sees.
                    if (cnt_q == 3'd0) begin
                        commit  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        stall_out = 1'b1;
                        cnt_d     = cnt_q - 3'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= 32'd0;
            flags_q    <= 4'd0;
            djnz_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rf_we_q <= commit && write_en;
            djnz_q  <= commit && is_djnz && alu_qnz;
            if (commit && write_en) begin
                rf_waddr_q <= rdest;
                rf_wdata_q <= alu_dout;
            end
            if (commit) begin
                flags_q <= flags_d;
            end
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign flags      = flags_q;
    assign djnz_taken = djnz_q;

endmodule
